pwm_hue_sequencer: RTL

- Controller that sequences three `pwm` instances (R, G, B) through a continuous colour-wheel fade.
- Generates each channel's duty_cycle word.
- Steps a ramp counter once every UPDATE_CYCLES clocks and walks a 6-phase hue wheel.
- Supports run, pause and idle control from top-level logic (buttons/switches).

---
 rtl/pwm_seq_pkg.sv | 24 ++
 rtl/pwm_hue_sequencer_tick_gen.sv | 44 ++++
 rtl/pwm_hue_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and constants for the RGB hue-wheel sequencer.
// The state enum, the wheel phase names and the duty width helper live here.
package pwm_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Wheel phases, named after the colour the phase fades towards.
    localparam logic [2:0] PH_RG = 3'd0;
    localparam logic [2:0] PH_G  = 3'd1;
    localparam logic [2:0] PH_GB = 3'd2;
    localparam logic [2:0] PH_B  = 3'd3;
    localparam logic [2:0] PH_BR = 3'd4;
    localparam logic [2:0] PH_RB = 3'd5;

    function automatic int duty_width(input int interval);
        return (interval > 32'sd1) ? $clog2(interval) : 32'sd1;
    endfunction

endpackage

// File: rtl/pwm_hue_sequencer_tick_gen.sv
// Update-rate timer: counts 0..UPDATE_CYCLES-1 while run is high and
// flags the last count as a tick; clr zeroes it, and it holds while run is low.
module tick_gen #(
    parameter int UPDATE_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int TW = (UPDATE_CYCLES > 1) ? $clog2(UPDATE_CYCLES) : 1;
    localparam logic [TW-1:0] LAST = TW'(UPDATE_CYCLES - 1);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    assign tick = run && !clr && (timer_q == LAST);

    // Next timer value: clear wins, then wrap on tick, else count or hold.
    always_comb begin
        timer_d = timer_q;
        if (clr) begin
            timer_d = {TW{1'b0}};
        end else if (tick) begin
            timer_d = {TW{1'b0}};
        end else if (run) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = timer_q;
        end
    end

    // Timer register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            timer_q <= {TW{1'b0}};
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/pwm_hue_sequencer.sv
// Colour-wheel fade controller producing R/G/B duty words for three pwm blocks.
// Define PWM_SEQ_ONESHOT_EN to stop in a DONE state after one revolution.
module pwm_hue_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int PWM_INTERVAL  = 1200,
    parameter int UPDATE_CYCLES = 10000,
    parameter int STEP_SIZE     = 1
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  enable,
    input  logic                                  hold,
    output logic [duty_width(PWM_INTERVAL)-1:0]   duty_r,
    output logic [duty_width(PWM_INTERVAL)-1:0]   duty_g,
    output logic [duty_width(PWM_INTERVAL)-1:0]   duty_b,
    output logic [2:0]                            phase,
    output logic                                  cycle_done
);

    localparam int DUTY_W = duty_width(PWM_INTERVAL);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PWM_INTERVAL - 1);
    localparam logic [DUTY_W:0]   STEP     = (DUTY_W + 1)'(STEP_SIZE);

    state_e            state_q, state_d;
    logic [2:0]        phase_q, phase_d;
    logic [DUTY_W-1:0] ramp_q, ramp_d;
    logic              cycle_done_q, cycle_done_d;
    logic [DUTY_W:0]   sum_s;
    logic              tick_s, clr_s, run_s;
    logic [DUTY_W-1:0] duty_r_s, duty_g_s, duty_b_s;

    assign clr_s = !enable || (state_q == IDLE) || (state_q == DONE);
    assign run_s = (state_q == RUN) && !hold;
    assign sum_s = {1'b0, ramp_q} + STEP;

    tick_gen #(
        .UPDATE_CYCLES(UPDATE_CYCLES)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr_s),
        .run  (run_s),
        .tick (tick_s)
    );

    // Next-state, ramp and phase logic; enable low overrides everything but reset.
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        ramp_d       = ramp_q;
        cycle_done_d = 1'b0;
        if (!enable) begin
            state_d = IDLE;
            phase_d = PH_RG;
            ramp_d  = {DUTY_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    phase_d = PH_RG;
                    ramp_d  = {DUTY_W{1'b0}};
                end
                RUN: begin
                    if (hold) begin
                        state_d = PAUSE;
                    end else if (tick_s && (ramp_q == DUTY_MAX)) begin
                        ramp_d       = {DUTY_W{1'b0}};
                        phase_d      = (phase_q == PH_RB) ? PH_RG : phase_q + 3'd1;
                        cycle_done_d = (phase_q == PH_RB);
`ifdef PWM_SEQ_ONESHOT_EN
                        // Last step of the wheel parks on full red instead of wrapping.
                        if (phase_q == PH_RB) begin
                            state_d = DONE;
                            ramp_d  = ramp_q;
                            phase_d = phase_q;
                        end else begin
                            state_d = RUN;
                        end
`endif
                    end else if (tick_s) begin
                        ramp_d = (sum_s > {1'b0, DUTY_MAX}) ? DUTY_MAX : sum_s[DUTY_W-1:0];
                    end else begin
                        state_d = RUN;
                    end
                end
                PAUSE: begin
                    state_d = hold ? PAUSE : RUN;
                end
                DONE: begin
`ifdef PWM_SEQ_ONESHOT_EN
                    state_d = DONE;
`else
                    state_d = IDLE;
                    phase_d = PH_RG;
                    ramp_d  = {DUTY_W{1'b0}};
`endif
                end
                default: begin
                    state_d = IDLE;
                    phase_d = PH_RG;
                    ramp_d  = {DUTY_W{1'b0}};
                end
            endcase
        end
    end

    // Sequencer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= PH_RG;
            ramp_q       <= {DUTY_W{1'b0}};
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            ramp_q       <= ramp_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // Duty decode straight from the registers so duties track ramp with no extra delay.
    always_comb begin
        duty_r_s = {DUTY_W{1'b0}};
        duty_g_s = {DUTY_W{1'b0}};
        duty_b_s = {DUTY_W{1'b0}};
        if (state_q != IDLE) begin
            case (phase_q)
                PH_RG: begin duty_r_s = DUTY_MAX;          duty_g_s = ramp_q;            end
                PH_G:  begin duty_r_s = DUTY_MAX - ramp_q; duty_g_s = DUTY_MAX;          end
                PH_GB: begin duty_g_s = DUTY_MAX;          duty_b_s = ramp_q;            end
                PH_B:  begin duty_g_s = DUTY_MAX - ramp_q; duty_b_s = DUTY_MAX;          end
                PH_BR: begin duty_r_s = ramp_q;            duty_b_s = DUTY_MAX;          end
                PH_RB: begin duty_r_s = DUTY_MAX;          duty_b_s = DUTY_MAX - ramp_q; end
                default: begin
                    duty_r_s = {DUTY_W{1'b0}};
                    duty_g_s = {DUTY_W{1'b0}};
                    duty_b_s = {DUTY_W{1'b0}};
                end
            endcase
        end else begin
            duty_r_s = {DUTY_W{1'b0}};
            duty_g_s = {DUTY_W{1'b0}};
            duty_b_s = {DUTY_W{1'b0}};
        end
    end

    assign duty_r     = duty_r_s;
    assign duty_g     = duty_g_s;
    assign duty_b     = duty_b_s;
    assign phase      = phase_q;
    assign cycle_done = cycle_done_q;

endmodule
